muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide execution unit for the multicycle core, sitting beside the ALU and driven by the same `start` / `will_be_done` handshake the control FSM already uses in its WAIT_ALU stage. It generalises the single-width ALU path:
- operand width is a parameter;
- multiply throughput (bits retired per cycle) is a parameter;
- all eight M-extension operations are computed with RISC-V-mandated corner-case results.

---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit (shift-add multiply,
//            restoring divide) with a start / will_be_done / done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN               = 32,
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dataA,
    input  logic [XLEN-1:0] dataB,
    output logic            busy,
    output logic            will_be_done,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int                c_M        = MUL_BITS_PER_CYCLE;
    localparam int                c_N_MUL    = XLEN / MUL_BITS_PER_CYCLE;
    localparam int                c_CNT_W    = $clog2(XLEN) + 1;
    localparam logic [c_CNT_W-1:0] c_MUL_LAST = c_CNT_W'(c_N_MUL - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LAST = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]    c_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_op;
    logic              r_neg_a;
    logic              r_neg_b;
    logic [XLEN-1:0]   r_mag;
    logic [2*XLEN-1:0] r_acc;
    logic [c_CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]   r_result;

    logic              w_sign_a;
    logic              w_sign_b;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_special;
    logic              w_cnt_last;

    logic [XLEN+c_M-1:0] w_pp;
    logic [XLEN+c_M-1:0] w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_nxt;
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic                w_qbit;
    logic [2*XLEN-1:0]   w_div_nxt;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quot;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_fix_result;

    assign busy         = (r_state != c_ST_IDLE);
    assign will_be_done = (r_state == c_ST_FIX);
    assign done         = (r_state == c_ST_DONE);
    assign result       = r_result;

    // Operand decode for the request presented in IDLE.
    always_comb begin
        w_sign_a = 1'b0;
        w_sign_b = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sign_a = 1'b1;
                w_sign_b = 1'b1;
            end
            3'b010:  w_sign_a = 1'b1;
            default: ;
        endcase
        w_neg_a    = w_sign_a & dataA[XLEN-1];
        w_neg_b    = w_sign_b & dataB[XLEN-1];
        w_mag_a    = w_neg_a ? -dataA : dataA;
        w_mag_b    = w_neg_b ? -dataB : dataB;
        w_div_zero = op[2] & (dataB == '0);
        w_div_ovf  = op[2] & ~op[0] & (dataA == c_INT_MIN) & (dataB == '1);
        w_special  = w_div_zero | w_div_ovf;
    end

    // Multiply step: r_acc = {partial high, remaining multiplier bits}.
    always_comb begin
        w_pp = '0;
        for (int i = 0; i < c_M; i++) begin
            if (r_acc[i]) begin
                w_pp = w_pp + ({{c_M{1'b0}}, r_mag} << i);
            end
        end
        w_mul_sum = {{c_M{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
        w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:c_M]};
    end

    // Divide step: r_acc = {partial remainder, dividend/quotient shift}.
    always_comb begin
        w_rem_sh  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_diff    = w_rem_sh - {1'b0, r_mag};
        w_qbit    = ~w_diff[XLEN];
        w_div_nxt = {(w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                     r_acc[XLEN-2:0], w_qbit};
    end

    always_comb begin
        w_prod       = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
        w_quot       = (r_neg_a ^ r_neg_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem        = r_neg_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        w_fix_result = '0;
        case (r_op)
            3'b000:         w_fix_result = w_prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         w_fix_result = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_fix_result = w_quot;
            default:        w_fix_result = w_rem;
        endcase
    end

    assign w_cnt_last = (r_cnt == (r_op[2] ? c_DIV_LAST : c_MUL_LAST));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start) w_state_nxt = w_special ? c_ST_FIX : c_ST_CALC;
            c_ST_CALC: if (w_cnt_last) w_state_nxt = c_ST_FIX;
            c_ST_FIX:  w_state_nxt = c_ST_DONE;
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_mag    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        if (w_special) begin
                            // Final quotient/remainder loaded directly, no sign fix-up.
                            r_neg_a <= 1'b0;
                            r_neg_b <= 1'b0;
                            r_mag   <= w_mag_b;
                            r_acc   <= w_div_zero ? {dataA, {XLEN{1'b1}}}
                                                  : {{XLEN{1'b0}}, dataA};
                        end else begin
                            r_neg_a <= w_neg_a;
                            r_neg_b <= w_neg_b;
                            r_mag   <= op[2] ? w_mag_b : w_mag_a;
                            r_acc   <= op[2] ? {{XLEN{1'b0}}, w_mag_a}
                                             : {{XLEN{1'b0}}, w_mag_b};
                        end
                    end
                end
                c_ST_CALC: begin
                    r_acc <= r_op[2] ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                c_ST_FIX: begin
                    r_result <= w_fix_result;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Self-checking bench for muldiv_unit, two instances (1 and 4
//            multiplier bits per cycle) sharing one stimulus stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        busy1, wbd1, done1;
    logic [31:0] result1;
    logic        busy4, wbd4, done4;
    logic [31:0] result4;

    int n_checks = 0;
    int n_fail   = 0;

    int          c1, c4, w1c, w4c;
    logic [31:0] r1, r4;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32), .MUL_BITS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .dataA(dataA), .dataB(dataB),
        .busy(busy1), .will_be_done(wbd1), .done(done1), .result(result1)
    );

    muldiv_unit #(.XLEN(32), .MUL_BITS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .dataA(dataA), .dataB(dataB),
        .busy(busy4), .will_be_done(wbd4), .done(done4), .result(result4)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // RISC-V M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_done(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b, input int mbpc);
        if (o[2]) begin
            if (b == 0) return 2;
            if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
            return 34;
        end
        return 32 / mbpc + 2;
    endfunction

    // Called #1 after a rising edge with both units idle.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op = o; dataA = a; dataB = b; start = 1'b1;
        c1 = -1; c4 = -1; w1c = -1; w4c = -1; r1 = '0; r4 = '0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) start = 1'b0;
            if (wbd1 && w1c < 0) w1c = cyc;
            if (wbd4 && w4c < 0) w4c = cyc;
            if (done1 && c1 < 0) begin c1 = cyc; r1 = result1; end
            if (done4 && c4 < 0) begin c4 = cyc; r4 = result4; end
            if (c1 >= 0 && c4 >= 0) break;
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [2:0] o, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        int e1, e4;
        e1 = exp_done(o, a, b, 1);
        e4 = exp_done(o, a, b, 4);
        run_op(o, a, b);
        check({name, " result(mbpc1)"}, 64'(r1), 64'(exp));
        check({name, " result(mbpc4)"}, 64'(r4), 64'(exp));
        check({name, " done cycle(mbpc1)"}, 64'(c1), 64'(e1));
        check({name, " done cycle(mbpc4)"}, 64'(c4), 64'(e4));
        check({name, " wbd cycle(mbpc1)"}, 64'(w1c), 64'(e1 - 1));
        check({name, " wbd cycle(mbpc4)"}, 64'(w4c), 64'(e4 - 1));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d1, n_done;
        logic [31:0] a, b;
        logic [2:0]  o;

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[5]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        vecs[6]  = '{3'd7, 32'd100,       32'd7,         32'd2};
        vecs[7]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[8]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
        vecs[10] = '{3'd6, 32'd5,         32'd0,         32'd5};
        vecs[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
        vecs[13] = '{3'd7, 32'hDEAD_BEEF, 32'd0,         32'hDEAD_BEEF};

        rst = 1'b1; start = 1'b0; op = '0; dataA = '0; dataB = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy1",   64'(busy1),   64'(0));
        check("reset done1",   64'(done1),   64'(0));
        check("reset wbd1",    64'(wbd1),    64'(0));
        check("reset result1", 64'(result1), 64'(0));
        check("reset busy4",   64'(busy4),   64'(0));
        check("reset result4", 64'(result4), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Requests during a running DIVU and in its DONE cycle are ignored.
        op = 3'd5; dataA = 32'd100; dataB = 32'd7; start = 1'b1;
        d1 = -1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 5)  begin op = 3'd0; dataA = 32'd3; dataB = 32'd5;  start = 1'b1; end
            if (cyc == 20) begin op = 3'd6; dataA = 32'd9; dataB = 32'd4;  start = 1'b1; end
            if (done1 && d1 < 0) begin
                d1 = cyc;
                check("ignored-start result1", 64'(result1), 64'(14));
                check("ignored-start result4", 64'(result4), 64'(14));
            end
            if (cyc == 34) begin op = 3'd0; dataA = 32'd3; dataB = 32'd4; start = 1'b1; end
            if (cyc == 35) check("start in DONE ignored busy c35", 64'(busy1), 64'(0));
            if (cyc == 36) check("start in DONE ignored busy c36", 64'(busy1), 64'(0));
        end
        check("ignored-start done cycle", 64'(d1), 64'(34));
        check("result holds after op", 64'(result1), 64'(14));

        // Reset in cycle 12 of a MUL discards it.
        op = 3'd0; dataA = 32'h0001_2345; dataB = 32'h0000_0777; start = 1'b1;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (cyc == 12) rst = 1'b1;
        end
        @(posedge clk); #1;
        check("post-reset busy1",   64'(busy1),   64'(0));
        check("post-reset result1", 64'(result1), 64'(0));
        check("post-reset busy4",   64'(busy4),   64'(0));
        check("post-reset result4", 64'(result4), 64'(0));
        rst = 1'b0;
        n_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            if (done1 || wbd1) n_done++;
        end
        check("no done after reset", 64'(n_done), 64'(0));
        check_op("mul 3x4 after reset", 3'd0, 32'd3, 32'd4, 32'd12);

        // Randomized operations against the reference model.
        for (int k = 0; k < 150; k++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 20);
                3: a = $urandom_range(0, 50);
                4: b = -32'($urandom_range(1, 20));
                default: ;
            endcase
            check_op($sformatf("rand%0d op%0d a=%h b=%h", k, o, a, b), o, a, b, ref_model(o, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
